pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Converts single-cycle request pulses on `in` into clean, fixed-width output pulses on `out`, with a guaranteed minimum low gap between pulses.
- It is the counterpart of the level-to-pulse generator. That block turns a level into a one-cycle pulse; this one turns one-cycle pulses back into wide, slow-logic-visible pulses plus a toggle level.
- It sits between the pulse generator and downstream LED/handshake logic.

Parameters:
- HIGH_CYCLES, 4, width of each `out` pulse in clk cycles (>=1, < 2^CNT_W).
- LOW_CYCLES, 2, minimum `out` low time after a pulse before the next pulse (>=0, < 2^CNT_W).
- CNT_W, 8, width of the internal down-counter.

Ports:
- clk  input  1  clock, rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- in  input  1  request; each cycle sampled high counts as one request.
- ovf_clr  input  1  synchronous clear of the `ovf` flag.
- out  output  1  stretched pulse, registered.
- busy  output  1  high while in HIGH or GAP state, registered.
- lvl  output  1  toggles at the start of every `out` pulse, registered.
- ovf  output  1  sticky: a request was dropped, registered.

Behaviour:
- Reset: clr_n and clk as decided; clr_n=0 asynchronously forces state=IDLE, cnt=0, pend=0, out=0, busy=0, lvl=0, ovf=0. `in` is ignored while clr_n=0.
- Convention: "cycle k" means `in` is sampled at posedge k and registered outputs change at that same edge.
- Moore FSM with states IDLE, HIGH, GAP. `out`=1 only in HIGH; `busy`=1 in HIGH or GAP.
- IDLE:
  - in=1 -> HIGH, cnt<=HIGH_CYCLES-1, lvl toggles.
  - Latency: `out` rises at the edge that samples `in`.
- HIGH:
  - cnt!=0 -> cnt decrements.
  - cnt==0 and LOW_CYCLES>0 -> GAP, cnt<=LOW_CYCLES-1.
  - cnt==0 and LOW_CYCLES==0 -> HIGH (reload, toggle lvl, clear pend) if pend, else IDLE.
  - Result: `out` stays high exactly HIGH_CYCLES cycles.
- GAP:
  - cnt!=0 -> cnt decrements.
  - cnt==0 -> if pend: HIGH, cnt<=HIGH_CYCLES-1, lvl toggles, pend<=0; else IDLE.
- Pending request (one deep):
  - in=1 while in HIGH or GAP and pend=0 -> pend<=1.
  - in=1 while pend=1 -> request dropped, ovf<=1.
- Simultaneous events:
  - pend consumed in the same cycle as a new in=1: pend stays 1, because the new request is captured.
  - `ovf` set and `ovf_clr` in the same cycle: set wins.
- Reset mid-pulse: `out` drops immediately and asynchronously; any pending request is lost; `lvl` returns to 0.
- No arithmetic wrap: cnt is only loaded with constants below 2^CNT_W and only decrements while non-zero.

Optional Feature:
- Macro: PULSE_STRETCHER_RETRIG_EN.
- Defined:
  - in=1 while in HIGH reloads cnt<=HIGH_CYCLES-1, extending the current pulse; it does not set pend or ovf, and lvl does not toggle.
  - in=1 during GAP uses the normal pend/ovf rules.
- Undefined: non-retriggerable behaviour exactly as described above.

Test Plan:
All scenarios use defaults HIGH_CYCLES=4, LOW_CYCLES=2.
- Reset: hold clr_n=0 with in=1 toggling -> out=busy=lvl=ovf=0 throughout; release, in=0 -> all outputs stay 0.
- Single request: in=1 at cycle 10 only -> out=1 cycles 10-13, busy=1 cycles 10-15, busy=0 at 16, lvl=1 from 10.
- Pending: in=1 at cycles 10 and 12 -> out=1 at 10-13 and 16-19, low at 14-15; lvl=1 at 10 and 0 at 16; ovf=0.
- Overflow: in=1 at cycles 10, 11, 12 -> ovf=1 at 12; only two out pulses (10-13, 16-19); ovf_clr at 25 -> ovf=0 at 25; ovf_clr together with a new drop -> ovf stays 1.
- Async reset mid-pulse: in=1 at 10, clr_n low mid-cycle 12 -> out=0 immediately with no clock edge; the pend set by in=1 at 11 is discarded; no pulse after clr_n is released.
- PULSE_STRETCHER_RETRIG_EN defined: in=1 at cycles 10 and 12 -> out=1 cycles 10-15 (6 cycles), then GAP 16-17, no second pulse, lvl toggles once, ovf=0.

Source files
------------

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretcher
// Purpose  : Turns one-cycle request pulses into fixed-width output pulses
//            (HIGH_CYCLES wide) separated by at least LOW_CYCLES low cycles.
//            One further request can wait in a pending slot; any request
//            beyond that is dropped and latched in a sticky overflow flag.
//            lvl toggles at the start of every output pulse.
// Ports    : clk      - clock, rising edge
//            clr_n    - asynchronous active-low reset
//            in       - request; every cycle sampled high is one request
//            ovf_clr  - synchronous clear of ovf (a same-cycle drop wins)
//            out      - stretched pulse (registered)
//            busy     - high while a pulse or its low gap is in progress
//            lvl      - toggle level, flips at each pulse start (registered)
//            ovf      - sticky dropped-request flag (registered)
// Options  : PULSE_STRETCHER_RETRIG_EN - when defined, a request arriving
//            during the high phase restarts the high count instead of
//            queueing, so the current pulse is extended.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic clr_n,
    input  logic in,
    input  logic ovf_clr,
    output logic out,
    output logic busy,
    output logic lvl,
    output logic ovf
);

`ifdef PULSE_STRETCHER_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    localparam logic [CNT_W-1:0] H_LOAD = CNT_W'(HIGH_CYCLES - 1);
    // Only used when LOW_CYCLES > 0; the guard keeps the constant in range.
    localparam logic [CNT_W-1:0] L_LOAD = (LOW_CYCLES > 0) ? CNT_W'(LOW_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pend, pend_nxt;
    logic             lvl_nxt, ovf_nxt;
    logic             queue;    // request that goes through the pending slot
    logic             consume;  // pending request launches a pulse this cycle
    logic             drop;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            out   <= 1'b0;
            busy  <= 1'b0;
            lvl   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            // Outputs are registered copies of the next state so they
            // change on the same edge as the state itself.
            out   <= (state_nxt == S_HIGH);
            busy  <= (state_nxt != S_IDLE);
            lvl   <= lvl_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lvl_nxt   = lvl;
        queue     = 1'b0;
        consume   = 1'b0;

        case (state)
            S_IDLE: begin
                if (in) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = H_LOAD;
                    lvl_nxt   = ~lvl;
                end
            end

            S_HIGH: begin
                if (RETRIG && in) begin
                    cnt_nxt = H_LOAD;
                end else begin
                    queue = in;
                    if (cnt != '0) begin
                        cnt_nxt = cnt - ONE;
                    end else if (LOW_CYCLES > 0) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = L_LOAD;
                    end else if (pend) begin
                        // No gap configured: back-to-back pulse.
                        cnt_nxt = H_LOAD;
                        lvl_nxt = ~lvl;
                        consume = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_GAP: begin
                queue = in;
                if (cnt != '0) begin
                    cnt_nxt = cnt - ONE;
                end else if (pend) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = H_LOAD;
                    lvl_nxt   = ~lvl;
                    consume   = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // A slot freed by consume in this cycle can take the new request,
        // so that case is a capture rather than a drop.
        drop     = queue & pend & ~consume;
        pend_nxt = (pend & ~consume) | queue;
        ovf_nxt  = drop | (ovf & ~ovf_clr);
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stretcher
// Purpose  : Directed self-checking bench for pulse_stretcher with default
//            parameters (HIGH_CYCLES=4, LOW_CYCLES=2). Cycle 0 of each
//            sequence is the edge that samples the first request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic in = 1'b0;
    logic ovf_clr = 1'b0;
    logic out, busy, lvl, ovf;

    int errors = 0;
    int checks = 0;

    pulse_stretcher #(
        .HIGH_CYCLES (4),
        .LOW_CYCLES  (2),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .in      (in),
        .ovf_clr (ovf_clr),
        .out     (out),
        .busy    (busy),
        .lvl     (lvl),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Mask with bits lo..hi set (cycle c corresponds to bit c).
    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic apply_reset();
        clr_n   = 1'b0;
        in      = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic run_seq(input string name, input int n,
                           input logic [31:0] inv, input logic [31:0] ocv,
                           input logic [31:0] eo, input logic [31:0] eb,
                           input logic [31:0] el, input logic [31:0] ev);
        for (int c = 0; c < n; c++) begin
            in      = inv[c];
            ovf_clr = ocv[c];
            @(posedge clk);
            #1;
            check($sformatf("%s c%0d out", name, c),  {31'd0, out},  {31'd0, eo[c]});
            check($sformatf("%s c%0d busy", name, c), {31'd0, busy}, {31'd0, eb[c]});
            check($sformatf("%s c%0d lvl", name, c),  {31'd0, lvl},  {31'd0, el[c]});
            check($sformatf("%s c%0d ovf", name, c),  {31'd0, ovf},  {31'd0, ev[c]});
        end
        in      = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        // Reset held with in toggling: everything stays low.
        clr_n = 1'b0;
        #1;
        check("rst t0 outs", {28'd0, out, busy, lvl, ovf}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            in = c[0];
            @(posedge clk);
            #1;
            check($sformatf("rst hold c%0d", c), {28'd0, out, busy, lvl, ovf}, 32'd0);
        end
        in = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        run_seq("rst rel", 4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Single request.
        apply_reset();
        run_seq("single", 8, rng(0, 0), 32'd0, rng(0, 3), rng(0, 5), rng(0, 7), 32'd0);

`ifndef PULSE_STRETCHER_RETRIG_EN
        // Pending request launches after the gap.
        apply_reset();
        run_seq("pend", 14, rng(0, 0) | rng(2, 2), 32'd0,
                rng(0, 3) | rng(6, 9), rng(0, 11), rng(0, 5), 32'd0);

        // Third request dropped; ovf_clr at cycle 15 clears the flag.
        apply_reset();
        run_seq("ovf", 17, rng(0, 2), rng(15, 15),
                rng(0, 3) | rng(6, 9), rng(0, 11), rng(0, 5), rng(2, 14));

        // Drop and ovf_clr in the same cycle: set wins.
        apply_reset();
        run_seq("ovf+clr", 5, rng(0, 2), rng(2, 2),
                rng(0, 3), rng(0, 4), rng(0, 4), rng(2, 4));
`else
        // Retrigger during HIGH extends the pulse; no second pulse.
        apply_reset();
        run_seq("retrig", 10, rng(0, 0) | rng(2, 2), 32'd0,
                rng(0, 5), rng(0, 7), rng(0, 9), 32'd0);
`endif

        // Asynchronous reset in the middle of a pulse with a request queued.
        apply_reset();
        run_seq("areset pre", 3, rng(0, 1), 32'd0, rng(0, 2), rng(0, 2), rng(0, 2), 32'd0);
        #2;
        clr_n = 1'b0;
        #1;
        check("areset immediate", {28'd0, out, busy, lvl, ovf}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        run_seq("areset post", 10, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
